alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
Sequential 6-bit ALU core. It produces the result word and the arithmetic flags that the downstream flag stage consumes: the parity flag block takes Dato, and the flag register takes CF/OF/ZF/SF. Single-cycle ops and multi-cycle ops (variable shift, shift-add multiply) share one start/done handshake. The result and flags are registered and held stable between operations.

Parameters:
WIDTH, 6, operand/result width; 6 is the only supported value for this revision.
MUL_CYCLES, WIDTH, iterations of the shift-add multiplier.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request; accepted only on an edge where busy=0.
op  input  3  operation code; sampled with start.
A  input  WIDTH  operand A; sampled with start.
B  input  WIDTH  operand B; sampled with start.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
Dato  output  WIDTH  registered result; feeds the parity flag stage.
CF  output  1  carry/borrow/shift-out.
OF  output  1  overflow.
ZF  output  1  result == 0.
SF  output  1  result MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
- Reset values (rst_n=0 at an edge):
  - state=IDLE.
  - busy, done, Dato, CF, OF, ZF, SF all 0.
  - A reset during an operation aborts it; no done is produced.
- FSM states: IDLE, EXEC, SHIFT, MULT, DONE.
  - IDLE/DONE with start=1: capture A, B, op; go to EXEC.
  - DONE with start=0: go to IDLE.
- Start acceptance:
  - start while busy=1 is ignored and not queued.
  - start during the DONE cycle is accepted, so back-to-back operations are allowed.
- Op codes:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL by s=B[2:0]
  - 110 MUL
  - 111 NOT A
- EXEC:
  - Single-cycle ops: write result and flags, go to DONE.
  - SHL: if s=0, go to DONE immediately; otherwise load the shift counter with s and go to SHIFT.
  - MUL: clear the accumulator, load counter=MUL_CYCLES, go to MULT.
- SHIFT: shift left one bit per cycle; CF takes the bit shifted out. When the counter reaches 0, go to DONE.
  - s of 6 or 7 yields Dato=0.
  - CF is the last bit shifted out.
- MULT: one shift-add step per cycle. After MUL_CYCLES steps, the full 2*WIDTH product is complete; go to DONE.
- Latency: start sampled at edge N → done=1 in the cycle after edge N+L.
  - L=1 for ADD, SUB, logic ops, NOT, and SHL with s=0.
  - L=1+s for SHL with s>0.
  - L=1+MUL_CYCLES (7) for MUL.
- busy: 1 from edge N until the edge entering DONE. busy=0 whenever done=1.
- done: high for exactly one cycle, in state DONE.
- Flag rules (WIDTH-bit arithmetic, two's complement for OF/SF):
  - ADD: CF=carry-out; OF=(A5==B5)&&(R5!=A5).
  - SUB: CF=borrow (A<B unsigned); OF=(A5!=B5)&&(R5!=A5).
  - AND/OR/XOR/NOT: CF=0, OF=0.
  - SHL: CF=last bit out (0 if s=0); OF=0.
  - MUL: Dato=product[5:0]; CF=OF=(product[11:6]!=0).
  - All ops: ZF=(Dato==0); SF=Dato[5].
- Hold behaviour: Dato and the flags change only on the edge entering DONE. Otherwise they hold, including through IDLE and during a new operation.
- Intermediate values: shift and multiply intermediates stay internal; Dato is not updated mid-operation.

Decomposition:
- Shared package alu_pkg: WIDTH; op code constants (OP_ADD..OP_NOT); FSM state encoding.
- One natural sub-module: alu_mul_shiftadd. It performs the iterative 6x6→12 multiply with load/step/finish control and is driven by the MULT state.
- Everything else stays in alu_seq_core.

Test Plan:
- ADD A=6'd31, B=6'd1 → done 1 cycle after start edge; Dato=6'd32, CF=0, OF=1, SF=1, ZF=0.
- SUB A=6'd3, B=6'd5 → Dato=6'd62, CF=1, OF=0, SF=1; then AND A=6'h2A, B=6'h15 → Dato=0, ZF=1, CF=0.
- SHL A=6'b110001, B=3'd2 → done in cycle after edge N+3; Dato=6'b000100, CF=1. Repeat with B=3'd7 → Dato=0, ZF=1, done after edge N+8.
- MUL A=6'd9, B=6'd7 → done after edge N+7; Dato=6'd63, CF=OF=0. MUL A=6'd8, B=6'd8 → Dato=0, ZF=1, CF=OF=1.
- Handshake: start pulsed during MULT busy → ignored, single done. start asserted in the DONE cycle → next op accepted, busy rises next cycle.
- rst_n=0 for one edge mid-MULT → all outputs 0, no done. The next start operates normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core: datapath width, op codes
// and FSM state encoding.
package alu_pkg;

    localparam int WIDTH = 6;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SHIFT,
        MULT,
        DONE
    } state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// Start/done request bus of the sequential ALU core: operands in, registered
// result and arithmetic flags out.
interface alu_seq_core_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Dato;
    logic             CF;
    logic             OF;
    logic             ZF;
    logic             SF;

    modport master (
        output start, op, A, B,
        input  busy, done, Dato, CF, OF, ZF, SF
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, Dato, CF, OF, ZF, SF
    );
endinterface

// File: rtl/alu_mul_shiftadd.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one
// partial product per step; prod_next is the accumulator after the current step.
module alu_mul_shiftadd #(
    parameter int WIDTH      = 6,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic                 fin
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign prod_next = acc + (mplier[0] ? mcand : '0);
    // fin marks the step that completes the product, so the caller can latch
    // prod_next on the same edge without an extra cycle.
    assign fin       = step && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(MUL_CYCLES);
        end else if (step && (cnt != '0)) begin
            acc    <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: single-cycle ops plus iterative shift and multiply
// behind one start/done handshake; result and flags held between operations.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = alu_pkg::WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_core_if.slave  bus
);
    state_e             state, state_nxt;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sh_q;
    logic [2:0]         sh_cnt;
    logic [WIDTH-1:0]   dato_q;
    logic               cf_q, of_q, zf_q, sf_q;

    logic               accept;
    logic               mul_load, mul_step, mul_fin;
    logic [2*WIDTH-1:0] mul_prod;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_res;
    logic               wr_cf, wr_of;
    logic [WIDTH:0]     sum, dif;

    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign bus.busy = (state == EXEC) || (state == SHIFT) || (state == MULT);
    assign bus.done = (state == DONE);
    assign bus.Dato = dato_q;
    assign bus.CF   = cf_q;
    assign bus.OF   = of_q;
    assign bus.ZF   = zf_q;
    assign bus.SF   = sf_q;

    alu_mul_shiftadd #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mul_load),
        .step      (mul_step),
        .a         (a_q),
        .b         (b_q),
        .prod_next (mul_prod),
        .fin       (mul_fin)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        wr_en     = 1'b0;
        wr_res    = dato_q;
        wr_cf     = 1'b0;
        wr_of     = 1'b0;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        dif       = {1'b0, a_q} - {1'b0, b_q};
        unique case (state)
            IDLE: if (bus.start) state_nxt = EXEC;
            EXEC: begin
                wr_en     = 1'b1;
                state_nxt = DONE;
                unique case (op_q)
                    OP_ADD: begin
                        wr_res = sum[WIDTH-1:0];
                        wr_cf  = sum[WIDTH];
                        wr_of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_SUB: begin
                        wr_res = dif[WIDTH-1:0];
                        wr_cf  = dif[WIDTH];
                        wr_of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_AND: wr_res = a_q & b_q;
                    OP_OR:  wr_res = a_q | b_q;
                    OP_XOR: wr_res = a_q ^ b_q;
                    OP_NOT: wr_res = ~a_q;
                    OP_SHL: begin
                        if (b_q[2:0] == 3'd0) begin
                            wr_res = a_q;
                        end else begin
                            wr_en     = 1'b0;
                            state_nxt = SHIFT;
                        end
                    end
                    OP_MUL: begin
                        wr_en     = 1'b0;
                        mul_load  = 1'b1;
                        state_nxt = MULT;
                    end
                endcase
            end
            SHIFT: begin
                if (sh_cnt == 3'd1) begin
                    wr_en     = 1'b1;
                    wr_res    = {sh_q[WIDTH-2:0], 1'b0};
                    wr_cf     = sh_q[WIDTH-1];
                    state_nxt = DONE;
                end
            end
            MULT: begin
                mul_step = 1'b1;
                if (mul_fin) begin
                    wr_en     = 1'b1;
                    wr_res    = mul_prod[WIDTH-1:0];
                    wr_cf     = |mul_prod[2*WIDTH-1:WIDTH];
                    wr_of     = |mul_prod[2*WIDTH-1:WIDTH];
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = bus.start ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            sh_q   <= '0;
            sh_cnt <= '0;
            dato_q <= '0;
            cf_q   <= 1'b0;
            of_q   <= 1'b0;
            zf_q   <= 1'b0;
            sf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= op_e'(bus.op);
            end
            if ((state == EXEC) && (op_q == OP_SHL)) begin
                sh_q   <= a_q;
                sh_cnt <= b_q[2:0];
            end else if (state == SHIFT) begin
                sh_q   <= sh_q << 1;
                sh_cnt <= sh_cnt - 3'd1;
            end
            if (wr_en) begin
                dato_q <= wr_res;
                cf_q   <= wr_cf;
                of_q   <= wr_of;
                zf_q   <= (wr_res == '0);
                sf_q   <= wr_res[WIDTH-1];
            end
        end
    end
endmodule
